mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-port, 16-word `memory` block between the instruction-fetch (IF) and load/store (LS) requesters of the RISC-V core.
- Arbitrates between the two sides round-robin and checks that the byte address is aligned and in range.
- Sequences one memory command per transaction and returns the read data or a write acknowledge to the winning requester.
- Sits between the core front-end/LSU and `memory`; it is the only driver of memory's `PC`, `rd`, `wr` and `i_data` inputs.

Parameters:
- DEPTH, 16, number of 32-bit words in the attached memory.
- IDX_W, 4, word-index width; must equal log2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  IF read request; held high until if_ack.
- if_addr  in  32  IF byte address.
- if_ack  out  1  one-cycle pulse: IF transaction complete.
- if_rdata  out  32  IF read data; valid while if_ack=1.
- if_err  out  1  valid with if_ack: misaligned or out-of-range address.
- ls_req  in  1  LS request; held high until ls_ack.
- ls_we  in  1  LS direction: 1 = write, 0 = read.
- ls_addr  in  32  LS byte address.
- ls_wdata  in  32  LS write data.
- ls_ack  out  1  one-cycle pulse: LS transaction complete.
- ls_rdata  out  32  LS read data; valid while ls_ack=1 and ls_we=0.
- ls_err  out  1  valid with ls_ack: address fault.
- mem_addr  out  32  to memory.PC = {(32-IDX_W) zeros, word index}.
- mem_rd  out  1  to memory.rd.
- mem_wr  out  1  to memory.wr.
- mem_wdata  out  32  to memory.i_data.
- mem_rdata  in  32  from memory.o_data (registered inside memory, 1-cycle latency).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered. Reset (async, rst_n=0) forces:
  - state = IDLE, last_grant = LS;
  - all outputs = 0.
- Memory contents are not affected by reset. A command whose issuing edge has not yet occurred when reset asserts is aborted; no write takes place.
- FSM states: IDLE, CMD, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If one request is high, grant it.
  - If both are high, grant the side that is not last_grant (round-robin). After reset the first tie goes to IF.
  - Decoding the granted address:
    - word index = addr[IDX_W+1:2];
    - a fault exists if addr[1:0] != 0 or addr[31:IDX_W+2] != 0.
  - Fault: go directly to RESP. Pulse ack with err=1 and rdata=0. No memory command is issued. last_grant is updated.
  - No fault: go to CMD and register the command outputs:
    - mem_addr = word index;
    - mem_rd = !we, mem_wr = we (IF always has we=0);
    - mem_wdata = ls_wdata for a write, otherwise 0;
    - last_grant = the granted side.
- CMD: lasts exactly one cycle, during which memory samples the command. Then:
  - clear mem_rd and mem_wr;
  - go to RESP.
- RESP: lasts exactly one cycle.
  - The ack of the granted side is 1 and err=0.
  - rdata = mem_rdata for a read, 0 for a write.
  - The next state is always IDLE. Requests are ignored in RESP, so a requester that is still holding req in the ack cycle is not served twice.
- Latency and throughput:
  - Normal transaction: ack in the 3rd cycle after the req is first sampled. The repeat rate is 1 transaction per 3 cycles.
  - Fault: ack in the 2nd cycle after the req is first sampled.
- Requester rules:
  - req, addr, we and wdata stay stable from assertion until ack.
  - req drops, or a new request is presented, the cycle after ack.
  - Dropping req before ack is illegal. The arbiter still completes the granted transaction, and a write still occurs.
- if_ack and ls_ack are never high in the same cycle. mem_rd and mem_wr are never high together.
- busy = (state != IDLE).

Decomposition:
- Package riscv_mem_pkg holds:
  - the state enum {IDLE, CMD, RESP};
  - the grant enum {GNT_IF, GNT_LS};
  - DEPTH and IDX_W defaults;
  - the fault-check function.
- One sub-module: mem_rr_pick, the combinational 2-way round-robin selector.
  - Inputs: if_req, ls_req, last_grant.
  - Outputs: gnt_valid, gnt_sel.

Test Plan:
- After reset, IF reads addr 0x08 (memory word 2 preloaded with 0xDEADBEEF) -> mem_rd=1 with mem_addr=2 in cycle 1; if_ack=1, if_rdata=0xDEADBEEF, if_err=0 in cycle 2.
- LS write 0x0C / 0x12345678, then LS read 0x0C -> mem_wr=1 with mem_addr=3, ls_ack with ls_rdata=0; the read then returns 0x12345678.
- if_req and ls_req both held high continuously -> grants alternate IF, LS, IF, LS, one ack every 3 cycles; first ack is if_ack.
- LS read 0x06 (misaligned) and LS read 0x40 (out of range) -> ls_ack with ls_err=1 and ls_rdata=0 one cycle after the req is sampled; mem_rd and mem_wr stay 0.
- rst_n pulsed low during the CMD of an LS write to 0x04 -> all outputs go to 0 immediately, state is IDLE and memory word 1 is unchanged; the next tie is granted to IF.
- Requester keeps req high through the ack cycle, then drops it -> exactly one ack and one memory command are produced.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the IF/LS memory arbiter.
package riscv_mem_pkg;

    localparam int DEF_DEPTH = 16;
    localparam int DEF_IDX_W = 4;

    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
    typedef enum logic {GNT_IF, GNT_LS} grant_t;

    // Byte address must be word aligned and land inside the attached memory.
    function automatic logic addr_fault(input logic [31:0] addr, input int depth);
        logic [31:0] word;
        word = addr >> 2;
        return (addr[1:0] != 2'b00) || (word >= 32'(depth));
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational 2-way round-robin selector between IF and LS requesters.
module mem_rr_pick
    import riscv_mem_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
    input  grant_t last_grant,
    output logic   gnt_valid,
    output grant_t gnt_sel
);

    always_comb begin
        gnt_valid = if_req | ls_req;
        gnt_sel   = GNT_IF;
        if (if_req && ls_req) begin
            gnt_sel = (last_grant == GNT_IF) ? GNT_LS : GNT_IF;
        end else if (ls_req) begin
            gnt_sel = GNT_LS;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port memory between instruction fetch and load/store,
// issuing one command per transaction and returning data or a fault.
module mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int IDX_W = DEF_IDX_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        ls_err,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    state_t      state_reg;
    grant_t      last_grant_reg;
    grant_t      sel_reg;
    logic        we_reg;
    logic        if_pass_reg;
    logic        ls_pass_reg;

    logic        gnt_valid;
    grant_t      gnt_sel;
    logic [31:0] req_addr;
    logic        req_we;
    logic        req_fault;

    mem_rr_pick u_pick (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .last_grant (last_grant_reg),
        .gnt_valid  (gnt_valid),
        .gnt_sel    (gnt_sel)
    );

    always_comb begin
        req_addr  = (gnt_sel == GNT_IF) ? if_addr : ls_addr;
        req_we    = (gnt_sel == GNT_LS) && ls_we;
        req_fault = addr_fault(req_addr, DEPTH);
    end

    // Memory read data only becomes valid in the RESP cycle, so it is steered
    // through a registered select rather than re-registered (which would add a cycle).
    assign if_rdata = if_pass_reg ? mem_rdata : 32'd0;
    assign ls_rdata = ls_pass_reg ? mem_rdata : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= GNT_LS;
            sel_reg        <= GNT_IF;
            we_reg         <= 1'b0;
            if_pass_reg    <= 1'b0;
            ls_pass_reg    <= 1'b0;
            if_ack         <= 1'b0;
            if_err         <= 1'b0;
            ls_ack         <= 1'b0;
            ls_err         <= 1'b0;
            mem_addr       <= 32'd0;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
            mem_wdata      <= 32'd0;
            busy           <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (gnt_valid) begin
                        sel_reg        <= gnt_sel;
                        last_grant_reg <= gnt_sel;
                        busy           <= 1'b1;
                        if (req_fault) begin
                            state_reg <= RESP;
                            if_ack    <= (gnt_sel == GNT_IF);
                            if_err    <= (gnt_sel == GNT_IF);
                            ls_ack    <= (gnt_sel == GNT_LS);
                            ls_err    <= (gnt_sel == GNT_LS);
                        end else begin
                            state_reg <= CMD;
                            we_reg    <= req_we;
                            mem_addr  <= {{(32-IDX_W){1'b0}}, req_addr[IDX_W+1:2]};
                            mem_rd    <= !req_we;
                            mem_wr    <= req_we;
                            mem_wdata <= req_we ? ls_wdata : 32'd0;
                        end
                    end
                end
                CMD: begin
                    state_reg   <= RESP;
                    mem_rd      <= 1'b0;
                    mem_wr      <= 1'b0;
                    mem_wdata   <= 32'd0;
                    if_ack      <= (sel_reg == GNT_IF);
                    ls_ack      <= (sel_reg == GNT_LS);
                    if_pass_reg <= (sel_reg == GNT_IF);
                    ls_pass_reg <= (sel_reg == GNT_LS) && !we_reg;
                end
                RESP: begin
                    state_reg   <= IDLE;
                    busy        <= 1'b0;
                    if_ack      <= 1'b0;
                    if_err      <= 1'b0;
                    ls_ack      <= 1'b0;
                    ls_err      <= 1'b0;
                    if_pass_reg <= 1'b0;
                    ls_pass_reg <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 16-word registered-read memory.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    logic [31:0] mem [16];
    logic        preload;

    int checks = 0;
    int errors = 0;
    int ack_cnt;
    int rd_cnt;
    logic exp_if;
    logic exp_ls;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_ack    (ls_ack),
        .ls_rdata  (ls_rdata),
        .ls_err    (ls_err),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: synchronous write, registered read, contents untouched by rst_n.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
            mem[1] <= 32'h1111_1111;
            mem[2] <= 32'hDEAD_BEEF;
        end else begin
            if (mem_wr) mem[mem_addr[3:0]] <= mem_wdata;
            if (mem_rd) mem_rdata <= mem[mem_addr[3:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %s ok: %h", tag, obs);
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; preload = 1'b1;
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
        repeat (2) @(negedge clk);
        check("rst_if_ack", {31'd0, if_ack}, 32'd0);
        check("rst_ls_ack", {31'd0, ls_ack}, 32'd0);
        check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        preload = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        // IF read of word 2
        if_req = 1; if_addr = 32'h08;
        @(negedge clk);
        check("if_rd_cmd", {31'd0, mem_rd}, 32'd1);
        check("if_rd_addr", mem_addr, 32'd2);
        check("if_rd_busy", {31'd0, busy}, 32'd1);
        check("if_rd_noack", {31'd0, if_ack}, 32'd0);
        @(negedge clk);
        check("if_rd_ack", {31'd0, if_ack}, 32'd1);
        check("if_rd_data", if_rdata, 32'hDEAD_BEEF);
        check("if_rd_err", {31'd0, if_err}, 32'd0);
        check("if_rd_cmd_clr", {31'd0, mem_rd}, 32'd0);
        if_req = 0;
        @(negedge clk);
        check("if_rd_idle_ack", {31'd0, if_ack}, 32'd0);
        check("if_rd_idle_busy", {31'd0, busy}, 32'd0);

        // LS write then read back word 3
        ls_req = 1; ls_we = 1; ls_addr = 32'h0C; ls_wdata = 32'h1234_5678;
        @(negedge clk);
        check("ls_wr_cmd", {31'd0, mem_wr}, 32'd1);
        check("ls_wr_rd0", {31'd0, mem_rd}, 32'd0);
        check("ls_wr_addr", mem_addr, 32'd3);
        check("ls_wr_data", mem_wdata, 32'h1234_5678);
        @(negedge clk);
        check("ls_wr_ack", {31'd0, ls_ack}, 32'd1);
        check("ls_wr_rdata", ls_rdata, 32'd0);
        check("ls_wr_err", {31'd0, ls_err}, 32'd0);
        check("mem3_written", mem[3], 32'h1234_5678);
        ls_req = 0; ls_we = 0;
        @(negedge clk);
        ls_req = 1; ls_addr = 32'h0C;
        @(negedge clk);
        check("ls_rd_cmd", {31'd0, mem_rd}, 32'd1);
        @(negedge clk);
        check("ls_rd_ack", {31'd0, ls_ack}, 32'd1);
        check("ls_rd_data", ls_rdata, 32'h1234_5678);
        ls_req = 0;
        @(negedge clk);

        // Both requesters held continuously: alternating grants, first to IF
        if_req = 1; if_addr = 32'h08; ls_req = 1; ls_we = 0; ls_addr = 32'h0C;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            exp_if = (c % 3 == 2) && ((c / 3) % 2 == 0);
            exp_ls = (c % 3 == 2) && ((c / 3) % 2 == 1);
            check($sformatf("rr_if_ack_c%0d", c), {31'd0, if_ack}, {31'd0, exp_if});
            check($sformatf("rr_ls_ack_c%0d", c), {31'd0, ls_ack}, {31'd0, exp_ls});
            if (exp_if) check($sformatf("rr_if_data_c%0d", c), if_rdata, 32'hDEAD_BEEF);
            if (exp_ls) check($sformatf("rr_ls_data_c%0d", c), ls_rdata, 32'h1234_5678);
        end
        if_req = 0; ls_req = 0;
        @(negedge clk);

        // Address faults: misaligned, then out of range
        ls_req = 1; ls_addr = 32'h06;
        @(negedge clk);
        check("mis_ack", {31'd0, ls_ack}, 32'd1);
        check("mis_err", {31'd0, ls_err}, 32'd1);
        check("mis_rdata", ls_rdata, 32'd0);
        check("mis_no_cmd", {30'd0, mem_rd, mem_wr}, 32'd0);
        ls_req = 0;
        @(negedge clk);
        check("mis_ack_clr", {31'd0, ls_ack}, 32'd0);
        ls_req = 1; ls_addr = 32'h40;
        @(negedge clk);
        check("oor_ack", {31'd0, ls_ack}, 32'd1);
        check("oor_err", {31'd0, ls_err}, 32'd1);
        check("oor_rdata", ls_rdata, 32'd0);
        check("oor_no_cmd", {30'd0, mem_rd, mem_wr}, 32'd0);
        ls_req = 0;
        @(negedge clk);

        // Reset during CMD of a write aborts it
        ls_req = 1; ls_we = 1; ls_addr = 32'h04; ls_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("abort_cmd", {31'd0, mem_wr}, 32'd1);
        #2 rst_n = 1'b0; ls_req = 0; ls_we = 0;
        #1;
        check("abort_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_mem_wdata", mem_wdata, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_mem1", mem[1], 32'h1111_1111);
        @(negedge clk);
        if_req = 1; if_addr = 32'h08; ls_req = 1; ls_addr = 32'h0C;
        @(negedge clk);
        check("post_rst_tie_rd", {31'd0, mem_rd}, 32'd1);
        check("post_rst_tie_addr", mem_addr, 32'd2);
        @(negedge clk);
        check("post_rst_if_ack", {31'd0, if_ack}, 32'd1);
        check("post_rst_ls_ack", {31'd0, ls_ack}, 32'd0);
        if_req = 0;
        repeat (3) @(negedge clk);
        check("post_rst_ls_ack2", {31'd0, ls_ack}, 32'd1);
        check("post_rst_ls_data", ls_rdata, 32'h1234_5678);
        ls_req = 0;
        @(negedge clk);

        // Req held through the ack edge, then dropped: one command, one ack
        ack_cnt = 0; rd_cnt = 0;
        if_req = 1; if_addr = 32'h08;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            if (c == 3) begin
                #1 if_req = 0;
            end
            @(negedge clk);
            ack_cnt += int'(if_ack);
            rd_cnt  += int'(mem_rd);
        end
        check("hold_ack_count", 32'(ack_cnt), 32'd1);
        check("hold_cmd_count", 32'(rd_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
